// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, and holds the IF/ID register.
// It also collects the two stacked PC halves that RET/RTI pop from data memory.
module fetch_stage #(
  parameter int          width      = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0002
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [width-1:0] imem_data,
  input  logic             fetch_pc_enable,
  input  logic             load_use,
  input  logic             flush,
  input  logic [1:0]       pc_sel,
  input  logic [31:0]      pc_jmp,
  input  logic             pop_pc1,
  input  logic             pop_pc2,
  input  logic [15:0]      mem_data,
  output logic [width-1:0] instruction,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus1,
  output logic             valid,
  output logic             pop_ready
);

  typedef enum logic [1:0] {POP_EMPTY, POP_HI, POP_FULL} pop_state_t;

  pop_state_t  pop_state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [15:0] pop_hi;
  logic [15:0] pop_lo;
  logic        pc_load;
  logic        pop_consume;

  assign pc_load     = fetch_pc_enable & ~load_use;
  assign pop_ready   = (pop_state == POP_FULL);
  assign pop_consume = pc_load & (pc_sel == 2'b10) & pop_ready;
  assign imem_addr   = pc;
  assign pc_plus1    = pc_out + 32'd1;

  // A popped-PC select before both halves have arrived leaves the PC where it is.
  always_comb begin
    pc_next = pc;
    case (pc_sel)
      2'b00: pc_next = pc + 32'd1;
      2'b01: pc_next = pc_jmp;
      2'b10: if (pop_ready) pc_next = {pop_hi, pop_lo};
      2'b11: pc_next = INT_VECTOR;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (pc_load) begin
      pc <= pc_next;
    end
  end

  // New pop captures take precedence over consuming a completed return address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_state <= POP_EMPTY;
      pop_hi    <= 16'h0000;
      pop_lo    <= 16'h0000;
    end else if (pop_pc1) begin
      pop_hi <= mem_data;
      if (pop_pc2) begin
        pop_lo    <= mem_data;
        pop_state <= POP_FULL;
      end else begin
        pop_state <= POP_HI;
      end
    end else if (pop_pc2 && pop_state == POP_HI) begin
      pop_lo    <= mem_data;
      pop_state <= POP_FULL;
    end else if (pop_consume) begin
      pop_state <= POP_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction <= '0;
      pc_out      <= 32'h0000_0000;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= '0;
      valid       <= 1'b0;
    end else if (!load_use) begin
      instruction <= imem_data;
      pc_out      <= pc;
      valid       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized control traffic
// compared against a flag-based behavioural model of the PC, IF/ID register and pop buffer.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] INT_VECTOR = 32'h0000_0002;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        fetch_pc_enable;
  logic        load_use;
  logic        flush;
  logic [1:0]  pc_sel;
  logic [31:0] pc_jmp;
  logic        pop_pc1;
  logic        pop_pc2;
  logic [15:0] mem_data;
  logic [15:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus1;
  logic        valid;
  logic        pop_ready;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [15:0] m_instr;
  logic [31:0] m_pcout;
  logic        m_valid;
  logic        have_hi;
  logic        have_lo;
  logic [15:0] m_hi;
  logic [15:0] m_lo;

  fetch_stage #(
    .width(16),
    .RESET_PC(RESET_PC),
    .INT_VECTOR(INT_VECTOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .fetch_pc_enable(fetch_pc_enable),
    .load_use(load_use),
    .flush(flush),
    .pc_sel(pc_sel),
    .pc_jmp(pc_jmp),
    .pop_pc1(pop_pc1),
    .pop_pc2(pop_pc2),
    .mem_data(mem_data),
    .instruction(instruction),
    .pc_out(pc_out),
    .pc_plus1(pc_plus1),
    .valid(valid),
    .pop_ready(pop_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: fixed words at 0..3, a scrambled pattern elsewhere
  function automatic logic [15:0] word(input logic [31:0] a);
    logic [15:0] r;
    case (a)
      32'd0:   r = 16'h1111;
      32'd1:   r = 16'h2222;
      32'd2:   r = 16'h3333;
      32'd3:   r = 16'h4444;
      default: r = (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A5A;
    endcase
    return r;
  endfunction

  assign imem_data = word(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc    = RESET_PC;
    m_instr = 16'h0000;
    m_pcout = 32'h0;
    m_valid = 1'b0;
    have_hi = 1'b0;
    have_lo = 1'b0;
    m_hi    = 16'h0;
    m_lo    = 16'h0;
  endtask

  task automatic modelEdge();
    logic        ready;
    logic        load;
    logic [31:0] npc;
    ready = have_hi && have_lo;
    load  = fetch_pc_enable && !load_use;
    npc   = m_pc;
    if (load) begin
      if (pc_sel == 2'd0)      npc = m_pc + 32'd1;
      else if (pc_sel == 2'd1) npc = pc_jmp;
      else if (pc_sel == 2'd2) npc = ready ? {m_hi, m_lo} : m_pc;
      else                     npc = INT_VECTOR;
    end
    if (flush) begin
      m_instr = 16'h0;
      m_valid = 1'b0;
    end else if (!load_use) begin
      m_instr = word(m_pc);
      m_pcout = m_pc;
      m_valid = 1'b1;
    end
    if (pop_pc1) begin
      m_hi    = mem_data;
      have_hi = 1'b1;
      have_lo = pop_pc2;
      if (pop_pc2) m_lo = mem_data;
    end else if (pop_pc2 && have_hi && !have_lo) begin
      m_lo    = mem_data;
      have_lo = 1'b1;
    end else if (load && pc_sel == 2'd2 && ready) begin
      have_hi = 1'b0;
      have_lo = 1'b0;
    end
    m_pc = npc;
  endtask

  task automatic checkAll();
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("instruction", {16'h0, instruction}, {16'h0, m_instr});
    checkOutput("pc_out", pc_out, m_pcout);
    checkOutput("pc_plus1", pc_plus1, m_pcout + 32'd1);
    checkOutput("valid", {31'h0, valid}, {31'h0, m_valid});
    checkOutput("pop_ready", {31'h0, pop_ready}, {31'h0, (have_hi && have_lo)});
  endtask

  task automatic applyStimulus(input logic en, input logic lu, input logic fl, input logic [1:0] sel,
                               input logic [31:0] jmp, input logic p1, input logic p2,
                               input logic [15:0] md);
    fetch_pc_enable = en;
    load_use        = lu;
    flush           = fl;
    pc_sel          = sel;
    pc_jmp          = jmp;
    pop_pc1         = p1;
    pop_pc2         = p2;
    mem_data        = md;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  logic [31:0] held_pc;

  initial begin
    rst = 1'b0;
    fetch_pc_enable = 1'b1;
    load_use = 1'b0;
    flush = 1'b0;
    pc_sel = 2'b00;
    pc_jmp = 32'h0;
    pop_pc1 = 1'b0;
    pop_pc2 = 1'b0;
    mem_data = 16'h0;
    modelReset();
    #12;
    checkOutput("reset_pc", imem_addr, RESET_PC);
    checkOutput("reset_instr", {16'h0, instruction}, 32'h0);
    checkOutput("reset_pc_out", pc_out, 32'h0);
    checkOutput("reset_pc_plus1", pc_plus1, 32'h1);
    checkOutput("reset_valid", {31'h0, valid}, 32'h0);
    checkOutput("reset_pop_ready", {31'h0, pop_ready}, 32'h0);

    @(negedge clk);
    rst = 1'b1;

    // Sequential fetch from RESET_PC
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    checkOutput("seq_instr0", {16'h0, instruction}, 32'h1111);
    checkOutput("seq_pcout0", pc_out, 32'h0);
    checkOutput("seq_plus0", pc_plus1, 32'h1);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    checkOutput("seq_instr1", {16'h0, instruction}, 32'h2222);
    checkOutput("seq_pcout1", pc_out, 32'h1);
    checkOutput("seq_plus1", pc_plus1, 32'h2);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    checkOutput("seq_instr2", {16'h0, instruction}, 32'h3333);
    checkOutput("seq_pcout2", pc_out, 32'h2);
    checkOutput("seq_plus2", pc_plus1, 32'h3);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    checkOutput("at_pc5", imem_addr, 32'h5);

    // Branch with flush inserts one bubble
    applyStimulus(1, 0, 1, 2'b01, 32'h40, 0, 0, 16'h0);
    checkOutput("br_valid", {31'h0, valid}, 32'h0);
    checkOutput("br_instr", {16'h0, instruction}, 32'h0);
    checkOutput("br_pc", imem_addr, 32'h40);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    checkOutput("br_target_instr", {16'h0, instruction}, {16'h0, word(32'h40)});
    checkOutput("br_target_pcout", pc_out, 32'h40);

    // Load-use stall at PC = 3
    applyStimulus(1, 0, 0, 2'b01, 32'h2, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    applyStimulus(1, 1, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    checkOutput("stall1_pc", imem_addr, 32'h3);
    checkOutput("stall1_instr", {16'h0, instruction}, 32'h3333);
    applyStimulus(1, 1, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    checkOutput("stall2_pc", imem_addr, 32'h3);
    checkOutput("stall2_instr", {16'h0, instruction}, 32'h3333);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
    checkOutput("stall_resume_instr", {16'h0, instruction}, 32'h4444);
    checkOutput("stall_resume_pc", imem_addr, 32'h4);

    // Return sequence
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 1, 0, 16'h0001);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 1, 16'h0020);
    checkOutput("ret_ready", {31'h0, pop_ready}, 32'h1);
    applyStimulus(1, 0, 0, 2'b10, 32'h0, 0, 0, 16'h0);
    checkOutput("ret_pc", imem_addr, 32'h0001_0020);
    checkOutput("ret_consumed", {31'h0, pop_ready}, 32'h0);

    // Early pop select holds the PC and keeps the high half
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 1, 0, 16'h0007);
    held_pc = imem_addr;
    applyStimulus(1, 0, 0, 2'b10, 32'h0, 0, 0, 16'h0);
    checkOutput("early_pc_hold", imem_addr, held_pc);
    checkOutput("early_not_ready", {31'h0, pop_ready}, 32'h0);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 1, 16'h0009);
    checkOutput("early_still_hi", {31'h0, pop_ready}, 32'h1);
    applyStimulus(1, 0, 0, 2'b10, 32'h0, 0, 0, 16'h0);
    checkOutput("early_ret_pc", imem_addr, 32'h0007_0009);

    // Interrupt vector
    applyStimulus(1, 0, 1, 2'b11, 32'h0, 0, 0, 16'h0);
    checkOutput("int_vector", imem_addr, INT_VECTOR);

    // PC wrap, then asynchronous reset while a pop is half done
    applyStimulus(1, 0, 0, 2'b01, 32'hFFFF_FFFF, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 1, 0, 16'hBEEF);
    checkOutput("wrap_pc", imem_addr, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset_pc", imem_addr, RESET_PC);
    checkOutput("midreset_pop_ready", {31'h0, pop_ready}, 32'h0);
    checkOutput("midreset_valid", {31'h0, valid}, 32'h0);
    checkOutput("midreset_instr", {16'h0, instruction}, 32'h0);
    // An immediate pop_pc2 must be ignored: the half-done pop was discarded
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 0, 0, 2'b00, 32'h0, 0, 1, 16'h1234);
    checkOutput("postreset_instr", {16'h0, instruction}, 32'h1111);
    checkOutput("postreset_no_pop", {31'h0, pop_ready}, 32'h0);

    // Randomized control traffic against the model
    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [1:0]  sel;
      logic [31:0] jmp;
      r = int'($urandom_range(0, 9));
      if (r < 5)       sel = 2'b00;
      else if (r < 7)  sel = 2'b01;
      else if (r < 9)  sel = 2'b10;
      else             sel = 2'b11;
      jmp = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0, sel, jmp,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                    16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register that sits directly upstream of the decode stage. It owns the 32-bit program counter and drives the instruction memory address. It latches the fetched 16-bit word and its PC into the IF/ID register consumed by decode. It also applies the redirect, stall, freeze and flush controls that decode and the control unit generate.

## Interface
- `width`, 16, instruction word width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `INT_VECTOR`, 32'h0000_0002, PC loaded when `pc_sel` = 2'b11.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `imem_addr` output 32: current PC, drives instruction memory.
- `imem_data` input width: instruction word at `imem_addr`, combinational read, valid in the same cycle.
- `fetch_pc_enable` input 1: 0 freezes the PC (control-unit freeze).
- `load_use` input 1: hazard stall; holds both the PC and the IF/ID register.
- `flush` input 1: squash; IF/ID register loads a NOP.
- `pc_sel` input 2: next-PC source. 00 = PC+1, 01 = `pc_jmp`, 10 = popped PC, 11 = `INT_VECTOR`.
- `pc_jmp` input 32: branch/jump/call target from the jump unit.
- `pop_pc1` input 1: capture `mem_data` as the popped PC high half.
- `pop_pc2` input 1: capture `mem_data` as the popped PC low half.
- `mem_data` input 16: data-memory read data carrying the stacked PC halves.
- `instruction` output width: IF/ID instruction to decode.
- `pc_out` output 32: PC of `instruction`.
- `pc_plus1` output 32: `pc_out` + 1, the return address pushed by call/interrupt.
- `valid` output 1: IF/ID holds a real (non-flushed) instruction.
- `pop_ready` output 1: both PC halves captured and not yet consumed.

## Operation
- **PC register.** `imem_addr` = PC.
  - `pc_load` = `fetch_pc_enable` & ~`load_use`. The PC updates only when `pc_load` = 1.
  - Next PC by `pc_sel`:
    - 00: PC + 1. Arithmetic is modulo 2^32, so 32'hFFFF_FFFF wraps to 0.
    - 01: `pc_jmp`.
    - 10: {pop_hi, pop_lo}, but only if `pop_ready` = 1. If `pop_ready` = 0, the PC holds.
    - 11: `INT_VECTOR`.
- **Pop FSM.** States EMPTY, HI, FULL. `pop_ready` = (state == FULL).
  - EMPTY: `pop_pc1` → capture pop_hi, go to HI.
  - HI: `pop_pc2` → capture pop_lo, go to FULL. `pop_pc1` in HI → recapture pop_hi, stay in HI.
  - FULL: a PC load with `pc_sel` = 10 consumes the value and returns to EMPTY. `pop_pc1` in FULL recaptures pop_hi and goes to HI (a new return sequence).
  - `pop_pc2` in EMPTY is ignored.
  - `pop_pc1` and `pop_pc2` in the same cycle: `mem_data` goes to both halves, go to FULL.
- **IF/ID register.** Priority is `flush` > `load_use` > normal.
  - `flush`: `instruction` = 0 (NOP), `valid` = 0, `pc_out` holds.
  - `load_use` (no flush): all IF/ID fields hold.
  - Normal: `instruction` = `imem_data`, `pc_out` = PC, `valid` = 1. `fetch_pc_enable` = 0 alone does not stall IF/ID; the same word is re-latched each cycle.
- `flush` has no effect on the PC. A redirect with flush loads the target and squashes the wrong-path word in the same edge.
- The second word of a two-word instruction (LDM) passes through unchanged. Decode interprets it.

## Timing
- Reset (`rst` = 0, asynchronous): PC = `RESET_PC`; `instruction` = 0; `pc_out` = 0; `valid` = 0; pop FSM EMPTY; pop_hi = pop_lo = 0; `pop_ready` = 0; `pc_plus1` = 1.
- Release: first edge with `rst` = 1 latches the word at `RESET_PC` into IF/ID.
- Fetch latency: word at PC appears on `instruction` 1 cycle after PC is presented.
- Redirect: `pc_sel` ≠ 00 at edge N gives PC = target after N. The target word is on `instruction` after edge N+1. With `flush` at edge N, exactly one bubble (`valid` = 0) is inserted.
- Stall: while `load_use` = 1, PC and IF/ID are frozen; fetch resumes on the first edge with `load_use` = 0.
- RET/RTI: `pop_pc1` at edge N, `pop_pc2` at N+1, earliest `pc_sel` = 10 load at N+2.
- Reset mid-operation (e.g. FSM in HI, or a stall active) returns everything to the reset values immediately, regardless of clk.

## Test plan
- Reset and sequential fetch:
  - Stimulus: release `rst`; imem[0..3] = 16'h1111, 16'h2222, 16'h3333, 16'h4444; `pc_sel` = 00; `fetch_pc_enable` = 1.
  - Response: `instruction` = 1111, 2222, 3333 on successive cycles; `pc_out` = 0, 1, 2; `pc_plus1` = 1, 2, 3.
- Branch with flush:
  - Stimulus: at PC = 5, `pc_sel` = 01, `pc_jmp` = 32'h40, `flush` = 1.
  - Response: next cycle `valid` = 0 and `instruction` = 0; following cycle `instruction` = imem[0x40], `pc_out` = 0x40.
- Load-use stall:
  - Stimulus: assert `load_use` for 2 cycles at PC = 3.
  - Response: PC stays 3 and `instruction` stays imem[2] for 2 cycles; then imem[3] is latched.
- Return sequence:
  - Stimulus: `pop_pc1` with `mem_data` = 16'h0001, next cycle `pop_pc2` with `mem_data` = 16'h0020, then `pc_sel` = 10.
  - Response: `pop_ready` = 1 before the load; PC = 32'h0001_0020; `pop_ready` = 0 after the load.
- Early pop select:
  - Stimulus: `pc_sel` = 10 with only `pop_pc1` done (`pop_ready` = 0).
  - Response: PC holds; FSM stays in HI.
- Wrap and reset mid-pop:
  - Stimulus: PC = 32'hFFFF_FFFF with `pc_sel` = 00; then assert `rst` = 0 while the FSM is in HI.
  - Response: PC wraps to 0; after reset, PC = `RESET_PC`, `pop_ready` = 0, `valid` = 0.
